weight_fetch_pp: RTL and testbench
==================================

// Module: weight_fetch_pp
// PURPOSE
//  Parametrised KxK conv-kernel + batch-norm parameter fetcher, the AXI4 read master feeding the conv engine.
//  Streams NUM sets of K*K weights (and optionally a BN pair per set) from DRAM into a 2-entry ping-pong buffer.
//  The next set is prefetched while the engine consumes the current one, so the engine sees back-to-back sets.
// PARAMETERS
//  K       3   kernel edge; K*K weight words per set (K = 1..5)
//  DW      32  weight/BN word width = AXI RDATA width (bytes per beat = DW/8)
//  AW      32  AXI address width
//  NW      16  width of the set counter
// PORTS
//  aclk        in   1        clock
//  aresetn     in   1        synchronous active-low reset
//  start       in   1        1-cycle pulse: latch base_w/base_bn/num, begin fetch (ignored while busy)
//  base_w      in   AW       byte address of set 0 weights; DW/8-aligned
//  base_bn     in   AW       byte address of BN pair 0; DW/8-aligned
//  num         in   NW       number of sets to deliver; 0 -> immediate done, no AXI traffic
//  bn_en       in   1        sampled when a set's fetch begins: 1 = also fetch BN pair for that set
//  araddr      out  AW       AXI AR address
//  arlen       out  8        AXI AR burst length-1 (INCR; arsize = log2(DW/8))
//  arvalid     out  1        AXI AR valid
//  arready     in   1        AXI AR ready
//  rdata       in   DW       AXI R data
//  rresp       in   2        AXI R response
//  rlast       in   1        AXI R last
//  rvalid      in   1        AXI R valid
//  rready      out  1        AXI R ready
//  w_data      out  K*K*DW   current set; word i (row-major, i = r*K + c) at [i*DW +: DW]
//  bn0, bn1    out  DW       current set BN scale/bias; 0 when the set was fetched with bn_en = 0
//  ready       out  1        current set valid
//  next        in   1        consume request (level)
//  busy        out  1        start accepted .. done
//  done        out  1        1-cycle pulse after the last set is consumed
//  err         out  1        sticky: any rresp != OKAY since last start
// BEHAVIOUR
//  Reset: all outputs 0; both buffers empty; FSM = IDLE; counters 0.
//  Fetch FSM: IDLE -> AR_W -> R_W -> [AR_BN -> R_BN] -> FILL -> (AR_W | WAIT | IDLE).
//   - AR_W: weight set s starts at base_w + s*K*K*DW/8. A burst never crosses a 4KB boundary:
//     arlen = min(remaining beats, beats to next 4KB) - 1. Split bursts repeat AR_W/R_W until all K*K words are in.
//   - AR_BN: one 2-beat burst at base_bn + b*2*DW/8. b counts only sets fetched with bn_en = 1.
//     A BN pair never straddles 4KB (caller aligns base_bn to 2*DW/8).
//   - arvalid stays high, with araddr/arlen stable, until arready. One outstanding burst at a time.
//   - rready = 1 only in R_W/R_BN. Beats are written to the fill buffer in arrival order.
//     The last beat of a burst must carry rlast; a mismatch sets err.
//   - FILL: marks the fill buffer full and advances the fill pointer. Goes to AR_W if sets remain
//     and the other buffer is empty, to WAIT if it is full, to IDLE once all num sets are fetched.
//  Consume side:
//   - ready = current buffer full. A set is consumed on a cycle with ready && next && armed.
//   - On consume: buffer freed, ready = 0 the next cycle, armed cleared.
//   - armed is set again on the first cycle next = 0.
//   - If the other buffer is already full, ready re-asserts 2 cycles after the consume cycle.
//   - w_data/bn0/bn1 are stable while ready = 1. They are don't-care while ready = 0.
//  Consume and FILL in the same cycle: both take effect; no set is lost or duplicated.
//  Latency: start -> arvalid 1 cycle. Last R beat of set 0 -> ready 2 cycles.
//  done: pulses the cycle after the num-th consume; busy falls in the same cycle.
//  err: still delivers data and completes the run. Cleared only by an accepted start or reset.
//  Reset mid-run: abandons the burst; arvalid/rready drop the cycle reset is sampled; all state returns to IDLE.
// TESTING
//  T1 K=3, num=1, bn_en=0, base_w=0x1000: one AR (addr 0x1000, arlen 8); w_data = mem words 0..8; bn0=bn1=0; done after next.
//  T2 num=48, bn_en raised after set 30 consumed: sets 32..47 carry BN pairs from base_bn+0,+8,..; weights match file order.
//  T3 base_w=0xFF0, K=3: two ARs (0xFF0 arlen 3, 0x1000 arlen 4); w_data correct; no 4KB crossing.
//  T4 engine holds next=0 for 200 cycles: fetch stalls in WAIT after 2 sets; arvalid stays 0; no overwrite.
//     After next, ready gap is exactly 1 cycle.
//  T5 rresp=SLVERR on beat 4 of set 2: err=1 from that beat; all sets still delivered; next start clears err.
//  T6 aresetn low mid-burst, with randomised arready/rvalid gaps: all outputs 0; a new start with num=2 completes correctly.

Source files
------------

// File: rtl/weight_fetch_pp.sv
// KxK conv-kernel + batch-norm parameter fetcher: an AXI4 read master that streams weight sets
// into a 2-entry ping-pong buffer so the conv engine sees back-to-back sets.
module weight_fetch_pp #(
    parameter int K  = 3,
    parameter int DW = 32,
    parameter int AW = 32,
    parameter int NW = 16
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              start,
    input  logic [AW-1:0]     base_w,
    input  logic [AW-1:0]     base_bn,
    input  logic [NW-1:0]     num,
    input  logic              bn_en,
    output logic [AW-1:0]     araddr,
    output logic [7:0]        arlen,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DW-1:0]     rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,
    output logic [K*K*DW-1:0] w_data,
    output logic [DW-1:0]     bn0,
    output logic [DW-1:0]     bn1,
    output logic              ready,
    input  logic              next,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int KK  = K * K;
    localparam int BB  = DW / 8;
    localparam int BSH = $clog2(BB);
    localparam int WIW = (KK > 1) ? $clog2(KK) : 1;
    localparam logic [WIW-1:0] LAST_W = WIW'(KK - 1);
    localparam logic [WIW-1:0] ONE_W  = 1;
    localparam logic [NW-1:0]  ONE_N  = 1;
    localparam logic [AW-1:0]  STEP   = AW'(BB);

    typedef enum logic [2:0] {
        S_IDLE, S_AR_W, S_R_W, S_AR_BN, S_R_BN, S_FILL, S_WAIT
    } state_t;

    state_t state, state_n;

    logic [AW-1:0]  w_ptr;
    logic [AW-1:0]  bn_ptr;
    logic [NW-1:0]  num_q;
    logic [NW-1:0]  fetch_cnt;
    logic [NW-1:0]  cons_cnt;
    logic [WIW-1:0] word_idx;
    logic [7:0]     beat_cnt;
    logic [7:0]     burst_len;
    logic           set_bn;
    logic           busy_q;
    logic           done_q;
    logic           err_q;

    logic [1:0][KK-1:0][DW-1:0] buf_w;
    logic [1:0][DW-1:0]         buf_bn0;
    logic [1:0][DW-1:0]         buf_bn1;
    logic [1:0]                 full;
    logic                       fill_ptr;
    logic                       rd_ptr;
    logic                       armed;
    logic                       gap;

    logic        start_ok;
    logic        ar_fire;
    logic        r_fire;
    logic        last_beat;
    logic        consume;
    logic        set_begin;
    logic [12:0] to4k_beats;
    logic [12:0] rem_beats;
    logic [12:0] min_beats;
    logic [7:0]  w_len;

    assign start_ok  = start && !busy_q && (state == S_IDLE);
    assign ar_fire   = arvalid && arready;
    assign r_fire    = rvalid && rready;
    assign last_beat = (beat_cnt == burst_len);
    assign consume   = ready && next && armed;
    // A new set begins on any entry into AR_W that is not a split-burst continuation.
    assign set_begin = (state_n == S_AR_W) && (state != S_AR_W) && (state != S_R_W);

    // Weight bursts are clipped so they never cross a 4KB page.
    assign to4k_beats = (13'h1000 - {1'b0, w_ptr[11:0]}) >> BSH;
    assign rem_beats  = 13'(KK) - 13'(word_idx);
    assign min_beats  = (rem_beats < to4k_beats) ? rem_beats : to4k_beats;
    assign w_len      = 8'(min_beats - 13'd1);

    always_ff @(posedge aclk) begin
        if (!aresetn) state <= S_IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (start_ok && (num != '0)) state_n = S_AR_W;
            S_AR_W:  if (arready) state_n = S_R_W;
            S_R_W: begin
                if (r_fire && last_beat) begin
                    if (word_idx != LAST_W) state_n = S_AR_W;
                    else if (set_bn)        state_n = S_AR_BN;
                    else                    state_n = S_FILL;
                end
            end
            S_AR_BN: if (arready) state_n = S_R_BN;
            S_R_BN:  if (r_fire && last_beat) state_n = S_FILL;
            S_FILL: begin
                if (fetch_cnt + ONE_N == num_q) state_n = S_IDLE;
                else if (full[!fill_ptr])       state_n = S_WAIT;
                else                            state_n = S_AR_W;
            end
            S_WAIT:  if (!full[fill_ptr]) state_n = S_AR_W;
            default: state_n = S_IDLE;
        endcase
    end

    // AXI handshakes are gated by reset so they drop in the very cycle reset is sampled.
    always_comb begin
        arvalid = 1'b0;
        araddr  = '0;
        arlen   = '0;
        rready  = 1'b0;
        case (state)
            S_AR_W: begin
                arvalid = aresetn;
                araddr  = w_ptr;
                arlen   = w_len;
            end
            S_AR_BN: begin
                arvalid = aresetn;
                araddr  = bn_ptr;
                arlen   = 8'd1;
            end
            S_R_W, S_R_BN: rready = aresetn;
            default: ;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            w_ptr     <= '0;
            bn_ptr    <= '0;
            num_q     <= '0;
            fetch_cnt <= '0;
            cons_cnt  <= '0;
            word_idx  <= '0;
            beat_cnt  <= '0;
            burst_len <= '0;
            set_bn    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            full      <= '0;
            fill_ptr  <= 1'b0;
            rd_ptr    <= 1'b0;
            armed     <= 1'b0;
            gap       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            gap    <= consume;
            if (!next) armed <= 1'b1;

            if (start_ok) begin
                num_q     <= num;
                fetch_cnt <= '0;
                cons_cnt  <= '0;
                word_idx  <= '0;
                w_ptr     <= base_w;
                bn_ptr    <= base_bn;
                err_q     <= 1'b0;
                full      <= '0;
                fill_ptr  <= 1'b0;
                rd_ptr    <= 1'b0;
                if (num == '0) done_q <= 1'b1;
                else           busy_q <= 1'b1;
            end

            if (set_begin) set_bn <= bn_en;

            if (ar_fire) begin
                burst_len <= arlen;
                beat_cnt  <= '0;
            end

            if (r_fire) begin
                beat_cnt <= beat_cnt + 8'd1;
                if ((rresp != 2'b00) || (rlast != last_beat)) err_q <= 1'b1;
                if (state == S_R_W) begin
                    w_ptr    <= w_ptr + STEP;
                    word_idx <= word_idx + ONE_W;
                end else begin
                    bn_ptr <= bn_ptr + STEP;
                end
            end

            if (state == S_FILL) begin
                full[fill_ptr] <= 1'b1;
                fill_ptr       <= !fill_ptr;
                fetch_cnt      <= fetch_cnt + ONE_N;
                word_idx       <= '0;
            end

            // FILL only ever targets the empty buffer, so it never collides with this clear.
            if (consume) begin
                full[rd_ptr] <= 1'b0;
                rd_ptr       <= !rd_ptr;
                armed        <= 1'b0;
                cons_cnt     <= cons_cnt + ONE_N;
                if (cons_cnt + ONE_N == num_q) begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                end
            end
        end
    end

    // Buffer storage carries no reset; outputs are masked by ready instead.
    always_ff @(posedge aclk) begin
        if (r_fire && (state == S_R_W)) buf_w[fill_ptr][word_idx] <= rdata;
        if (r_fire && (state == S_R_BN)) begin
            if (beat_cnt == 8'd0) buf_bn0[fill_ptr] <= rdata;
            else                  buf_bn1[fill_ptr] <= rdata;
        end
        if ((state == S_FILL) && !set_bn) begin
            buf_bn0[fill_ptr] <= '0;
            buf_bn1[fill_ptr] <= '0;
        end
    end

    assign ready  = full[rd_ptr] && !gap;
    assign w_data = ready ? buf_w[rd_ptr]   : '0;
    assign bn0    = ready ? buf_bn0[rd_ptr] : '0;
    assign bn1    = ready ? buf_bn1[rd_ptr] : '0;
    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;

endmodule

// File: tb/tb_weight_fetch_pp.sv
// Directed bench for weight_fetch_pp: AXI read slave model with a synthetic memory, a consumer,
// a table of fetch configurations and hand-written stall / error / reset sequences.
module tb_weight_fetch_pp;
    localparam int K  = 3;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NW = 16;
    localparam int KK = K * K;

    logic              aclk;
    logic              aresetn;
    logic              start;
    logic [AW-1:0]     base_w;
    logic [AW-1:0]     base_bn;
    logic [NW-1:0]     num;
    logic              bn_en;
    logic [AW-1:0]     araddr;
    logic [7:0]        arlen;
    logic              arvalid;
    logic              arready;
    logic [DW-1:0]     rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;
    logic [KK*DW-1:0]  w_data;
    logic [DW-1:0]     bn0;
    logic [DW-1:0]     bn1;
    logic              ready;
    logic              next;
    logic              busy;
    logic              done;
    logic              err;

    weight_fetch_pp #(.K(K), .DW(DW), .AW(AW), .NW(NW)) dut (
        .aclk(aclk), .aresetn(aresetn), .start(start), .base_w(base_w), .base_bn(base_bn),
        .num(num), .bn_en(bn_en), .araddr(araddr), .arlen(arlen), .arvalid(arvalid),
        .arready(arready), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready), .w_data(w_data), .bn0(bn0), .bn1(bn1), .ready(ready), .next(next),
        .busy(busy), .done(done), .err(err)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    // slave model state
    bit          gaps = 1'b0;
    logic [31:0] err_addr = 32'hFFFF_FFFF;
    logic [31:0] ar_addr_q[$];
    int          ar_len_q[$];
    int          cross_4k = 0;
    int          last_r_cyc = 0;
    int          first_ready_cyc = 0;
    bit          stuck = 1'b0;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    function automatic logic [KK*DW-1:0] exp_w(input logic [31:0] bw, input int s);
        logic [KK*DW-1:0] v;
        for (int i = 0; i < KK; i++) v[i*DW +: DW] = memw(bw + 32'((s * KK + i) * 4));
        return v;
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // AXI read slave: samples handshakes at the edge, drives new values 1 time unit later.
    initial begin
        logic [31:0] s_addr;
        int          s_len;
        int          s_beat;
        bit          s_busy;
        bit          hs_ar;
        bit          hs_r;
        logic [31:0] a;
        int          l;
        int          e;
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = '0; rresp = 2'b00;
        s_addr = '0; s_len = 0; s_beat = 0; s_busy = 1'b0;
        forever begin
            @(posedge aclk);
            hs_ar = arvalid && arready;
            hs_r  = rvalid && rready;
            a = araddr;
            l = int'(arlen);
            e = cyc;
            #1;
            if (!aresetn) begin
                s_busy = 1'b0; arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
            end else begin
                if (hs_r) begin
                    if (s_beat == s_len) begin
                        s_busy = 1'b0;
                        last_r_cyc = e;
                    end
                    s_beat++;
                end
                if (hs_ar) begin
                    ar_addr_q.push_back(a);
                    ar_len_q.push_back(l);
                    if (int'(a[11:0]) + (l + 1) * 4 > 4096) cross_4k++;
                    s_addr = a; s_len = l; s_beat = 0; s_busy = 1'b1;
                end
                arready = !s_busy && (!gaps || ($urandom_range(0, 1) == 1));
                if (!(rvalid && !hs_r)) begin
                    if (s_busy && (!gaps || ($urandom_range(0, 2) != 0))) begin
                        rvalid = 1'b1;
                        rdata  = memw(s_addr + 32'(s_beat * 4));
                        rlast  = (s_beat == s_len);
                        rresp  = ((s_addr + 32'(s_beat * 4)) == err_addr) ? 2'b10 : 2'b00;
                    end else begin
                        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
                    end
                end
            end
        end
    end

    task automatic consume(input logic [KK*DW-1:0] ew, input logic [31:0] e0, input logic [31:0] e1,
                           input int s);
        int t = 0;
        while (ready !== 1'b1 && t < (stuck ? 0 : 3000)) begin @(negedge aclk); t++; end
        chk($sformatf("ready_wait[%0d]", s), ready, 1'b1);
        if (ready !== 1'b1) begin
            stuck = 1'b1;
            return;
        end
        if (s == 0) first_ready_cyc = cyc;
        chk($sformatf("w_data[%0d]", s), w_data, ew);
        chk($sformatf("bn0[%0d]", s), bn0, e0);
        chk($sformatf("bn1[%0d]", s), bn1, e1);
        next = 1'b1;
        @(negedge aclk);
        next = 1'b0;
    endtask

    // bnm: 0 = no BN, 1 = BN on every set, 2 = bn_en raised once set 30 is consumed
    task automatic run(input logic [31:0] bw, input logic [31:0] bb, input int n, input int bnm);
        int          bcnt = 0;
        bit          bnset;
        logic [31:0] e0;
        logic [31:0] e1;
        ar_addr_q.delete();
        ar_len_q.delete();
        bn_en = (bnm == 1);
        base_w = bw; base_bn = bb; num = NW'(n);
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        chk("err_clear_on_start", err, 1'b0);
        if (n == 0) begin
            chk("zero_num_done", done, 1'b1);
            chk("zero_num_arvalid", arvalid, 1'b0);
        end else begin
            chk("start_to_arvalid", arvalid, 1'b1);
        end
        for (int s = 0; s < n; s++) begin
            bnset = (bnm == 1) || (bnm == 2 && s >= 32);
            e0 = bnset ? memw(bb + 32'(bcnt * 8))     : 32'h0;
            e1 = bnset ? memw(bb + 32'(bcnt * 8 + 4)) : 32'h0;
            if (bnset) bcnt++;
            consume(exp_w(bw, s), e0, e1, s);
            if (bnm == 2 && s == 30) bn_en = 1'b1;
            if (s == n - 1) begin
                chk("done_pulse", done, 1'b1);
                chk("busy_fall", busy, 1'b0);
                @(negedge aclk);
                chk("done_one_cycle", done, 1'b0);
            end
        end
        bn_en = 1'b0;
    endtask

    typedef struct {
        logic [31:0] bw;
        logic [31:0] bb;
        int          n;
        int          bnm;
        int          n_ar;
        int          len0;
        logic [31:0] addr1;
        int          len1;
    } vec_t;

    initial begin
        vec_t vecs[5];
        int   av;

        vecs[0] = '{32'h0000_1000, 32'h0,         1, 0, 1, 8, 32'h0,         0};
        vecs[1] = '{32'h0000_0FF0, 32'h0,         1, 0, 2, 3, 32'h0000_1000, 4};
        vecs[2] = '{32'h0000_0FDC, 32'h0,         2, 0, 2, 8, 32'h0000_1000, 8};
        vecs[3] = '{32'h0000_2000, 32'h0000_8000, 3, 1, 6, 8, 32'h0000_8000, 1};
        vecs[4] = '{32'h0000_3000, 32'h0,         0, 0, 0, 0, 32'h0,         0};

        aresetn = 1'b0; start = 1'b0; base_w = '0; base_bn = '0; num = '0; bn_en = 1'b0; next = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_arvalid", arvalid, 1'b0);
        chk("rst_rready", rready, 1'b0);
        chk("rst_araddr", araddr, 32'h0);
        chk("rst_ready", ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_w_data", w_data, '0);
        aresetn = 1'b1;
        @(negedge aclk);

        for (int v = 0; v < 5; v++) begin
            run(vecs[v].bw, vecs[v].bb, vecs[v].n, vecs[v].bnm);
            chk($sformatf("vec%0d_ar_count", v), ar_addr_q.size(), vecs[v].n_ar);
            if (vecs[v].n_ar > 0 && ar_addr_q.size() > 0) begin
                chk($sformatf("vec%0d_ar0_addr", v), ar_addr_q[0], vecs[v].bw);
                chk($sformatf("vec%0d_ar0_len", v), ar_len_q[0], vecs[v].len0);
            end
            if (vecs[v].n_ar > 1 && ar_addr_q.size() > 1) begin
                chk($sformatf("vec%0d_ar1_addr", v), ar_addr_q[1], vecs[v].addr1);
                chk($sformatf("vec%0d_ar1_len", v), ar_len_q[1], vecs[v].len1);
            end
            // single weight-only set: ready two cycles after its last R beat
            if (vecs[v].n == 1 && vecs[v].bnm == 0)
                chk($sformatf("vec%0d_ready_latency", v), first_ready_cyc - last_r_cyc, 2);
        end

        // 48 sets, BN switched on mid-stream
        run(32'h0001_0000, 32'h0002_0000, 48, 2);
        chk("t2_ar_count", ar_addr_q.size(), 48 + 16);

        // Engine stall: two sets buffered, fetch parks, no overwrite, 1-cycle ready gap
        ar_addr_q.delete(); ar_len_q.delete();
        base_w = 32'h0000_4000; base_bn = '0; num = 16'd4;
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        av = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge aclk);
            if (c >= 50 && arvalid) av++;
        end
        chk("t4_stall_ars", ar_addr_q.size(), 2);
        chk("t4_stall_arvalid_cycles", av, 0);
        chk("t4_ready_held", ready, 1'b1);
        chk("t4_set0_kept", w_data, exp_w(32'h0000_4000, 0));
        next = 1'b1;
        @(negedge aclk);
        next = 1'b0;
        chk("t4_gap_ready_low", ready, 1'b0);
        @(negedge aclk);
        chk("t4_gap_ready_back", ready, 1'b1);
        chk("t4_set1_not_overwritten", w_data, exp_w(32'h0000_4000, 1));
        for (int s = 1; s < 4; s++) consume(exp_w(32'h0000_4000, s), 32'h0, 32'h0, s);
        chk("t4_done", done, 1'b1);
        @(negedge aclk);

        // SLVERR on beat 4 of set 2: data still delivered, err sticky, cleared by next start
        err_addr = 32'h0000_5000 + 32'((2 * KK + 4) * 4);
        run(32'h0000_5000, 32'h0, 4, 0);
        chk("t5_err_sticky", err, 1'b1);
        err_addr = 32'hFFFF_FFFF;
        run(32'h0000_6000, 32'h0, 1, 0);
        chk("t5_err_after_clean_run", err, 1'b0);

        // Reset mid-burst with random handshake gaps, then a clean two-set run
        gaps = 1'b1;
        base_w = 32'h0000_7000; base_bn = 32'h0000_9000; num = 16'd4; bn_en = 1'b1;
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        repeat (15) @(negedge aclk);
        aresetn = 1'b0;
        #1;
        chk("t6_arvalid_drop", arvalid, 1'b0);
        chk("t6_rready_drop", rready, 1'b0);
        @(negedge aclk);
        chk("t6_rst_ready", ready, 1'b0);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_done", done, 1'b0);
        chk("t6_rst_w_data", w_data, '0);
        chk("t6_rst_bn0", bn0, 32'h0);
        chk("t6_rst_arvalid", arvalid, 1'b0);
        aresetn = 1'b1;
        bn_en = 1'b0;
        @(negedge aclk);
        run(32'h0000_7100, 32'h0000_9100, 2, 1);
        chk("t6_ar_count", ar_addr_q.size(), 4);
        gaps = 1'b0;

        chk("no_4k_crossing", cross_4k, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
